// File: rtl/fpga_link_receiver.sv
// ============================================================================
// Module      : fpga_link_receiver
// Description : Receiving end of the inter-FPGA serial link. Reassembles one
//               byte per frame using a 4-phase acknowledge handshake per bit
//               and per end-of-frame. Optional macro FPGA_LINK_RX_SYNC_EN
//               adds two-flop input synchronizers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpga_link_receiver #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       send,
  input  logic       data_bit,
  input  logic       finish,
  output logic       acknowledge,
  output logic [7:0] data_out,
  output logic       received,
  output logic       frame_error,
  output logic       busy
);

  localparam int unsigned c_tmo_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_tmo_w-1:0] c_tmo_last =
    c_tmo_w'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACK_BIT = 2'd1,
    ST_ACK_FIN = 2'd2
  } state_t;

  logic w_send_s;
  logic w_data_bit_s;
  logic w_finish_s;

`ifdef FPGA_LINK_RX_SYNC_EN
  logic [1:0] r_send_sync;
  logic [1:0] r_data_sync;
  logic [1:0] r_finish_sync;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_send_sync   <= 2'b00;
      r_data_sync   <= 2'b00;
      r_finish_sync <= 2'b00;
    end else begin
      r_send_sync   <= {r_send_sync[0], send};
      r_data_sync   <= {r_data_sync[0], data_bit};
      r_finish_sync <= {r_finish_sync[0], finish};
    end
  end

  assign w_send_s     = r_send_sync[1];
  assign w_data_bit_s = r_data_sync[1];
  assign w_finish_s   = r_finish_sync[1];
`else
  assign w_send_s     = send;
  assign w_data_bit_s = data_bit;
  assign w_finish_s   = finish;
`endif

  state_t               r_state, w_state_next;
  logic [3:0]           r_bit_cnt, w_bit_cnt_next;
  logic [7:0]           r_shift, w_shift_next;
  logic [7:0]           r_data_out, w_data_out_next;
  logic                 r_received, w_received_next;
  logic                 r_frame_error, w_frame_error_next;
  logic [c_tmo_w-1:0]   r_tmo_cnt, w_tmo_cnt_next;
  logic                 w_tmo_active;
  logic                 w_tmo_hit;

  assign w_tmo_active = (r_state != ST_IDLE) || (r_bit_cnt != 4'd0);
  assign w_tmo_hit    = (TIMEOUT_CYCLES != 0) && w_tmo_active && (r_tmo_cnt == c_tmo_last);

  always_comb begin
    w_state_next       = r_state;
    w_bit_cnt_next     = r_bit_cnt;
    w_shift_next       = r_shift;
    w_data_out_next    = r_data_out;
    w_received_next    = 1'b0;
    w_frame_error_next = 1'b0;
    w_tmo_cnt_next     = '0;

    case (r_state)
      ST_IDLE: begin
        if (w_send_s && w_finish_s) begin
          w_frame_error_next = 1'b1;
          w_state_next       = ST_ACK_FIN;
        end else if (w_send_s) begin
          if (!r_bit_cnt[3]) begin
            w_shift_next[r_bit_cnt[2:0]] = w_data_bit_s;
            w_bit_cnt_next               = r_bit_cnt + 4'd1;
            w_state_next                 = ST_ACK_BIT;
          end else begin
            // A ninth bit overruns the byte
            w_frame_error_next = 1'b1;
            w_state_next       = ST_ACK_FIN;
          end
        end else if (w_finish_s) begin
          if (r_bit_cnt == 4'd8) begin
            w_data_out_next = r_shift;
            w_received_next = 1'b1;
          end else begin
            w_frame_error_next = 1'b1;
          end
          w_state_next = ST_ACK_FIN;
        end
      end
      ST_ACK_BIT: begin
        if (!w_send_s) w_state_next = ST_IDLE;
      end
      ST_ACK_FIN: begin
        if (!w_send_s && !w_finish_s) begin
          w_bit_cnt_next = 4'd0;
          w_shift_next   = 8'h00;
          w_state_next   = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    // A stalled frame overrides whatever the handshake decoded this cycle
    if (w_tmo_hit) begin
      w_state_next       = ST_IDLE;
      w_bit_cnt_next     = 4'd0;
      w_shift_next       = 8'h00;
      w_data_out_next    = r_data_out;
      w_received_next    = 1'b0;
      w_frame_error_next = 1'b1;
    end else if ((TIMEOUT_CYCLES != 0) && w_tmo_active && (w_state_next == r_state)) begin
      w_tmo_cnt_next = r_tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_bit_cnt     <= 4'd0;
      r_shift       <= 8'h00;
      r_data_out    <= 8'h00;
      r_received    <= 1'b0;
      r_frame_error <= 1'b0;
      r_tmo_cnt     <= '0;
    end else begin
      r_state       <= w_state_next;
      r_bit_cnt     <= w_bit_cnt_next;
      r_shift       <= w_shift_next;
      r_data_out    <= w_data_out_next;
      r_received    <= w_received_next;
      r_frame_error <= w_frame_error_next;
      r_tmo_cnt     <= w_tmo_cnt_next;
    end
  end

  assign acknowledge = (r_state != ST_IDLE);
  assign data_out    = r_data_out;
  assign received    = r_received;
  assign frame_error = r_frame_error;
  assign busy        = (r_state != ST_IDLE) || (r_bit_cnt != 4'd0);

endmodule

`default_nettype wire

// File: doc/fpga_link_receiver.md
# fpga_link_receiver

Receiving end of the inter-FPGA serial link driven by `fpga_transmitter`. Reassembles one 8-bit byte from the `send`/`data_bit`/`finish` wires using a 4-phase `acknowledge` handshake per bit and one for the end-of-frame. Delivers the byte on `data_out` with a one-cycle `received` strobe. Flags malformed or stalled frames on `frame_error`.

## Interface
- `TIMEOUT_CYCLES`, default 1024: maximum cycles spent waiting mid-frame before abort; 0 disables the timeout.
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `send`  in  1  bit strobe from the transmitter; asynchronous to `clock`.
- `data_bit`  in  1  serial data; stable while `send` is high.
- `finish`  in  1  end-of-frame strobe from the transmitter; asynchronous.
- `acknowledge`  out  1  handshake response to the transmitter.
- `data_out`  out  8  last correctly received byte; held until the next good frame.
- `received`  out  1  one-cycle pulse when `data_out` updates.
- `frame_error`  out  1  one-cycle pulse on a protocol error or timeout.
- `busy`  out  1  high while a frame is in progress (`bit_cnt`≠0 or state≠IDLE).

## Operation
- Bit order: LSB first. Bit n is written to `shift[n]`. `bit_cnt` is 4 bits wide and runs 0..8.
- State `IDLE` (`acknowledge`=0):
  - `send_s`=1 and `finish_s`=0 and `bit_cnt`<8: `shift[bit_cnt]`←`data_bit_s`, `bit_cnt`++, go to `ACK_BIT`.
  - `finish_s`=1 and `send_s`=0:
    - if `bit_cnt`==8: `data_out`←`shift`, pulse `received`.
    - otherwise: pulse `frame_error` and leave `data_out` unchanged.
    - In both cases go to `ACK_FIN`.
  - `send_s`=1 with `bit_cnt`==8 (extra bit), or `send_s`=1 and `finish_s`=1 together: pulse `frame_error`, go to `ACK_FIN`.
- State `ACK_BIT` (`acknowledge`=1): when `send_s`=0, go to `IDLE`.
- State `ACK_FIN` (`acknowledge`=1): when `send_s`=0 and `finish_s`=0, clear `bit_cnt` and `shift`, go to `IDLE`.
- Timeout:
  - A counter runs in `ACK_BIT`, in `ACK_FIN`, and in `IDLE` with `bit_cnt`≠0.
  - It clears on every state change.
  - When it reaches `TIMEOUT_CYCLES`: pulse `frame_error`, clear `bit_cnt`, `shift` and the counter, go to `IDLE` with `acknowledge`=0.
  - `data_out` is untouched.
- `received` and `frame_error` are never high in the same cycle.

## Timing
- Reset values: `acknowledge`=0, `data_out`=8'h00, `received`=0, `frame_error`=0, `busy`=0. State=`IDLE`, `bit_cnt`=0, `shift`=0, timeout counter=0, synchronizer flops=0.
- Reset mid-frame aborts the frame silently: no `frame_error`, and `acknowledge` drops on the reset edge.
- `_s` denotes the synchronized input.
  - With sync enabled: an input edge reaches `_s` 2 clocks later, and `acknowledge` changes on the 3rd rising edge after the input edge.
  - With sync disabled: the raw input is used, and `acknowledge` changes on the 1st edge.
- `received` and `data_out` update on the same edge that raises `acknowledge` for `finish`.
- `frame_error` is asserted on the same edge as the state transition that detects the error.
- Full byte, sync enabled: 9 handshakes, each ≥ 3 + 3 cycles of receiver latency. The transmitter gates progress only on `acknowledge`.

## Configuration
- `FPGA_LINK_RX_SYNC_EN` defined: two-flop synchronizers on `send`, `data_bit` and `finish` (3-cycle response latency). Required for board-to-board use.
- Undefined: inputs are sampled directly (1-cycle latency). Only for same-clock simulation with `fpga_transmitter`.
- Functional behaviour is otherwise identical.

## Test plan
- Transmit 8'h01, then 8'hA5 → `data_out`=8'h01, then 8'hA5, each with exactly one `received` pulse and 9 `acknowledge` high periods per frame.
- Transmit 8'hFF, then 8'h00 back-to-back → `data_out`=8'hFF, then 8'h00, with no `frame_error`.
- Raise `finish` after 5 bits → `frame_error` pulse, `data_out` keeps its previous value, `bit_cnt`=0 after `finish` drops.
- Drive `send` and `finish` high together → `frame_error`, `acknowledge` high until both are low, then `IDLE`.
- With `TIMEOUT_CYCLES`=16, stop the transmitter after 3 bits → `frame_error` 16 cycles after the last state change, `acknowledge`=0, `busy`=0. A following 8'h3C frame is received correctly.
- Assert `reset` while in `ACK_BIT` → `acknowledge`=0 and `data_out`=8'h00 next edge, no `frame_error`. The next 8'h81 frame is received correctly.
